// File: rtl/noc_output_arbiter_pkg.sv
// Shared NoC types: flit layout, source tag width, output-register states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

  localparam int FLIT_W = 11;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 7;
  localparam int SRC_W  = 3;

  localparam logic [SRC_W-1:0] CORE_ID = 3'd4;

  // Single-flit packet; the data field carries a Hamming-coded payload
  // that the arbiter never looks at.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } flit_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Handshake bundle between packet sources, the output arbiter and the link.
// Ports: in_valid/in_data/in_ready per requester, out_valid/out_data/out_src/out_ready to the link.
// master = traffic side (sources + downstream sink), slave = arbiter.
interface noc_output_arbiter_if #(
  parameter int NUM_IN = 5,
  parameter int WIDTH  = noc_pkg::FLIT_W,
  parameter int SRC_W  = noc_pkg::SRC_W
);

  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SRC_W-1:0]        out_src;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/noc_output_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping past N-1.
// Latency: combinational. Ports: req, ptr in; one-hot grant and binary idx out.
// Backpressure: none; the caller gates the grant.
module rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  // One spare bit so ptr+k cannot overflow before the modulo fold.
  logic [IDX_W:0] pos;
  logic           found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      // ptr < N, so one subtraction is enough to wrap.
      if (pos >= (IDX_W+1)'(N)) begin
        pos = pos - (IDX_W+1)'(N);
      end
      if (!found && req[pos[IDX_W-1:0]]) begin
        found                 = 1'b1;
        grant[pos[IDX_W-1:0]] = 1'b1;
        idx                   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Round-robin share of one output link among 4 neighbours + core, one-entry output register tagged with source.
// Latency: 1 cycle accept-to-out_valid; 1 flit/cycle when out_ready stays high.
// Backpressure: FULL & !out_ready drops every in_ready. Optional NOC_ARB_STATS_EN adds stats_clr/grant_cnt.
module noc_output_arbiter #(
  parameter int NUM_IN = 5,
  parameter int WIDTH  = noc_pkg::FLIT_W,
  parameter int SRC_W  = noc_pkg::SRC_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef NOC_ARB_STATS_EN
  input  logic                 stats_clr,
  output logic [NUM_IN*16-1:0] grant_cnt,
`endif
  noc_output_arbiter_if.slave  bus
);

  import noc_pkg::*;

  arb_state_e        state_q, state_d;
  logic [SRC_W-1:0]  rr_ptr_q;
  logic [SRC_W-1:0]  win_idx;
  logic [NUM_IN-1:0] win_oh;
  logic [NUM_IN-1:0] xfer;
  logic [WIDTH-1:0]  out_data_q;
  logic [SRC_W-1:0]  out_src_q;
  logic              can_load;
  logic              load;

  rr_pick #(
    .N     (NUM_IN),
    .IDX_W (SRC_W)
  ) u_pick (
    .req   (bus.in_valid),
    .ptr   (rr_ptr_q),
    .grant (win_oh),
    .idx   (win_idx)
  );

  // The register can take a flit if empty or if its current flit leaves this cycle.
  assign can_load     = (state_q == EMPTY) | bus.out_ready;
  assign bus.in_ready = (rst_n & can_load) ? win_oh : '0;
  assign xfer         = bus.in_valid & bus.in_ready;
  assign load         = |xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL: begin
        if (load) begin
          state_d = FULL;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // out_data/out_src only move on a load, so they hold through a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_src_q  <= '0;
      rr_ptr_q   <= '0;
    end else if (load) begin
      out_data_q <= bus.in_data[win_idx*WIDTH +: WIDTH];
      out_src_q  <= win_idx;
      rr_ptr_q   <= (win_idx == SRC_W'(NUM_IN-1)) ? '0 : win_idx + 1'b1;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef NOC_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_IN];

  // A clear coinciding with a grant leaves that counter at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (stats_clr) begin
          cnt_q[i] <= {15'd0, xfer[i]};
        end else if (xfer[i] && cnt_q[i] != 16'hFFFF) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Synchronous round-robin arbiter that shares one router output link among the packet sources of a node: four neighbour split paths (index 0-3) and the local core (index 4).
- Accepts 11-bit single-flit packets, laid out as {data[6:0] Hamming-coded, addr[3:0]}, using valid/ready handshakes.
- Buffers the granted flit in a one-entry output register and tags it with the winning source index. That tag becomes the 3-bit control ID forwarded downstream.

Parameters:
- NUM_IN, 5, number of requesters; index NUM_IN-1 is the core.
- WIDTH, 11, flit width.
- SRC_W, 3, width of the source tag; must satisfy 2**SRC_W >= NUM_IN.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  NUM_IN  per-requester flit valid
- in_data  in  NUM_IN*WIDTH  per-requester flit; requester i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  NUM_IN  one-hot grant/accept; combinational
- out_valid  out  1  output register holds a flit
- out_data  out  WIDTH  buffered flit
- out_src  out  SRC_W  index of the requester that supplied out_data
- out_ready  in  1  downstream accepts the flit

Behaviour:
- Reset (asserted asynchronously, released synchronously by the clocking):
  - out_valid=0, out_data=0, out_src=0.
  - rr_ptr=0, state=EMPTY.
  - in_ready=0 while rst_n is low.
- State machine on the output register: EMPTY, FULL.
- can_load = (state==EMPTY) | out_ready.
- Arbitration (combinational):
  - Search for the first asserted in_valid starting at rr_ptr and moving upward, wrapping from NUM_IN-1 to 0.
  - The winner w receives in_ready[w]=1 only when can_load=1. At most one in_ready bit is high at any time.
- Transfer: requester i transfers on a cycle where in_valid[i] & in_ready[i]. On that edge:
  - out_data <= in_data[w], out_src <= w, state <= FULL.
  - rr_ptr <= (w==NUM_IN-1) ? 0 : w+1.
- Drain:
  - out_valid & out_ready with no new winner → state <= EMPTY, out_valid <= 0. out_data and out_src hold their last values.
  - Drain and load in the same cycle → register reloads and stays FULL, giving 1 flit/cycle throughput.
- State transitions:
  - FULL & !out_ready: hold. out_data and out_src stay stable, and all in_ready bits are 0 (backpressure).
  - EMPTY & no in_valid: stay EMPTY. rr_ptr is unchanged.
- Latency: 1 cycle from the accepting edge to out_valid.
- Fairness: a requester that holds valid waits at most NUM_IN-1 grants.
- Input rules: an in_valid deassertion without a transfer is legal (the requester drops out of arbitration). in_data must stay stable while valid and not yet accepted.
- Reset mid-operation: the buffered flit is discarded without being delivered, and rr_ptr returns to 0.
- The arbiter does not inspect or modify flit contents: no parity check, no address decode.

Optional Feature:
- Macro: NOC_ARB_STATS_EN.
- Defined:
  - Adds an output grant_cnt (NUM_IN*16 bits), a 16-bit per-requester count of accepted flits.
  - Counters are reset to 0 by rst_n and saturate at 16'hFFFF.
  - Adds an input stats_clr (1 bit), a synchronous clear; if a grant lands in the same cycle as the clear, that counter's next value is 1.
- Not defined: grant_cnt and stats_clr are absent, and there is no extra logic.

Decomposition:
- Shared package noc_pkg contains:
  - FLIT_W=11, ADDR_W=4, DATA_W=7, SRC_W=3, CORE_ID=3'd4.
  - typedef flit_t (packed struct {data[6:0], addr[3:0]}).
  - typedef arb_state_e {EMPTY, FULL}.
- Sub-module rr_pick (combinational): inputs are the request vector and the pointer; outputs are a one-hot grant and a binary index. It is reusable by the input-side arbiters.

Test Plan:
- Reset: drive rst_n=0 in the middle of a FULL period → out_valid drops to 0 in the same cycle without waiting for a clock edge. After release, a single request on in_valid[2] leaves rr_ptr at 0 and is granted.
- Round robin: all 5 in_valid held high with out_ready=1 → out_src sequence 0,1,2,3,4,0, one flit every cycle. Each out_data must equal its source's in_data.
- Backpressure: out_ready=0 for 4 cycles with in_valid[1]=1 → out_data holds 11'h5A3 and in_ready=0 throughout. When out_ready=1, that flit drains and the next flit loads on the same edge.
- Wrap-around: with rr_ptr=4 and requests on 4 and 0 → order is 4 then 0. With rr_ptr=4 and only in_valid[1] → 1 is granted and rr_ptr becomes 2.
- Idle/drop: in_valid[3] is pulsed for 1 cycle while FULL and stalled → no transfer occurs, no flit with out_src=3 appears, and rr_ptr is unchanged.
- Stats (NOC_ARB_STATS_EN): 10 core flits → grant_cnt[4]=10 and all other counters are 0. Asserting stats_clr in the same cycle as a core grant → grant_cnt[4]=1.
